fx_bus_arb: RTL and testbench

FX_BUS_ARB -- requirements
Module: fx_bus_arb

---
 rtl/fx_bus_pkg.sv | 30 +++
 rtl/fx_bus_arb_if.sv | 41 ++++
 rtl/fx_rr_arb2.sv | 35 +++
 rtl/fx_bus_arb.sv | 156 +++++++++++++++
 tb/tb_fx_bus_arb.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fx_bus_pkg.sv
// Shared fx bus widths, module-id field position, FSM states and request bundle.
// No logic; no latency or backpressure of its own.
package fx_bus_pkg;

    localparam int FX_AW      = 16;
    localparam int FX_DW      = 8;
    localparam int FX_MID_LSB = 8;
    localparam int FX_MID_MSB = 13;
    localparam int FX_MID_W   = FX_MID_MSB - FX_MID_LSB + 1;
    localparam int FX_CNT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } fx_state_e;

    typedef struct packed {
        logic             we;
        logic [FX_AW-1:0] addr;
        logic [FX_DW-1:0] wdata;
    } fx_req_t;

    function automatic logic [FX_MID_W-1:0] fx_mod_id(input logic [FX_AW-1:0] addr);
        return addr[FX_MID_MSB:FX_MID_LSB];
    endfunction

endpackage

// File: rtl/fx_bus_arb_if.sv
// Requester ports and shared fx bus master side of the arbiter.
// Wires only; requesters hold req/we/addr/wdata stable until their done pulse.
interface fx_bus_arb_if;
    import fx_bus_pkg::*;

    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [FX_AW-1:0] addr0;
    logic [FX_AW-1:0] addr1;
    logic [FX_DW-1:0] wdata0;
    logic [FX_DW-1:0] wdata1;
    logic             done0;
    logic             done1;
    logic [FX_DW-1:0] rdata0;
    logic [FX_DW-1:0] rdata1;

    logic             fx_wr;
    logic             fx_rd;
    logic [FX_AW-1:0] fx_waddr;
    logic [FX_AW-1:0] fx_raddr;
    logic [FX_DW-1:0] fx_data;
    logic [FX_DW-1:0] fx_q;
    logic             busy;

    // Arbiter view: serves the requesters and masters the fx bus.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, fx_q,
        output done0, done1, rdata0, rdata1,
        output fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, busy
    );

    // Environment view: requesters plus OR-combined slave read data.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, fx_q,
        input  done0, done1, rdata0, rdata1,
        input  fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, busy
    );

endinterface

// File: rtl/fx_rr_arb2.sv
// Two-way round-robin grant: combinational grant, pointer updated on en_i.
// Zero latency; no backpressure, a lone request always wins.
module fx_rr_arb2 (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 means requester 1 was granted most recently.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (en_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset as if requester 1 went last, so requester 0 wins the first contention.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fx_bus_arb.sv
// Two-requester fx bus arbiter: write done 2 cycles after req, read done RD_LAT+2.
// Requests sampled only in IDLE; one transaction in flight, all outputs registered.
module fx_bus_arb
    import fx_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    fx_bus_arb_if.slave  bus
);

    localparam logic [FX_CNT_W-1:0] WAIT_INIT = FX_CNT_W'(RD_LAT - 1);

    fx_state_e            state_q;
    fx_state_e            state_d;
    logic [FX_CNT_W-1:0]  cnt_q;
    logic [FX_CNT_W-1:0]  cnt_d;
    logic                 owner_q;
    logic                 owner_d;

    logic [1:0]           gnt;
    logic                 gnt_en;
    fx_req_t              sel;

    logic                 fx_wr_q;
    logic                 fx_rd_q;
    logic [FX_AW-1:0]     fx_waddr_q;
    logic [FX_AW-1:0]     fx_raddr_q;
    logic [FX_DW-1:0]     fx_data_q;
    logic                 done0_q;
    logic                 done1_q;
    logic [FX_DW-1:0]     rdata0_q;
    logic [FX_DW-1:0]     rdata1_q;
    logic                 busy_q;
    logic                 capture;

    fx_rr_arb2 u_rr (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .req_i   ({bus.req1, bus.req0}),
        .en_i    (gnt_en),
        .gnt_o   (gnt)
    );

    always_comb begin
        sel = '0;
        if (gnt[0]) begin
            sel.we    = bus.we0;
            sel.addr  = bus.addr0;
            sel.wdata = bus.wdata0;
        end else begin
            sel.we    = bus.we1;
            sel.addr  = bus.addr1;
            sel.wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        gnt_en  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_en  = 1'b1;
                    owner_d = gnt[1];
                    state_d = sel.we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
            end
            ST_RD: begin
                cnt_d   = WAIT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // fx_q is taken on the last WAIT cycle, RD_LAT cycles after fx_rd.
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_raddr_q <= '0;
            fx_data_q  <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            fx_wr_q <= (state_d == ST_WR);
            fx_rd_q <= (state_d == ST_RD);
            busy_q  <= (state_d != ST_IDLE);
            done0_q <= (state_d == ST_DONE) && !owner_d;
            done1_q <= (state_d == ST_DONE) && owner_d;
            // Bus address/data registers double as the transaction latch and hold afterwards.
            if (gnt_en && sel.we) begin
                fx_waddr_q <= sel.addr;
                fx_data_q  <= sel.wdata;
            end
            if (gnt_en && !sel.we) begin
                fx_raddr_q <= sel.addr;
            end
            if (capture && !owner_q) begin
                rdata0_q <= bus.fx_q;
            end
            if (capture && owner_q) begin
                rdata1_q <= bus.fx_q;
            end
        end
    end

    assign bus.fx_wr    = fx_wr_q;
    assign bus.fx_rd    = fx_rd_q;
    assign bus.fx_waddr = fx_waddr_q;
    assign bus.fx_raddr = fx_raddr_q;
    assign bus.fx_data  = fx_data_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Directed bench for fx_bus_arb: one instance with RD_LAT=1, one with RD_LAT=3.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_fx_bus_arb;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    fx_bus_arb_if b1 ();
    fx_bus_arb_if b3 ();

    fx_bus_arb #(.RD_LAT(1)) u_dut1 (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (b1)
    );

    fx_bus_arb #(.RD_LAT(3)) u_dut3 (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RD_LAT=1 read on instance 1 with slave data driven in the cycle after fx_rd.
    task automatic rd1(input bit who, input logic [15:0] a, input logic [7:0] q, input string tag);
        if (!who) begin
            b1.req0 = 1'b1; b1.we0 = 1'b0; b1.addr0 = a;
        end else begin
            b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = a;
        end
        tick;
        chk({tag, "_rd"}, b1.fx_rd, 1);
        chk({tag, "_raddr"}, b1.fx_raddr, a);
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
        tick;
        b1.fx_q = q;
        tick;
        b1.fx_q = 8'h00;
        chk({tag, "_done"}, who ? b1.done1 : b1.done0, 1);
        chk({tag, "_rdata"}, who ? b1.rdata1 : b1.rdata0, q);
        tick;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        {b1.req0, b1.req1, b1.we0, b1.we1} = '0;
        {b1.addr0, b1.addr1, b1.wdata0, b1.wdata1, b1.fx_q} = '0;
        {b3.req0, b3.req1, b3.we0, b3.we1} = '0;
        {b3.addr0, b3.addr1, b3.wdata0, b3.wdata1, b3.fx_q} = '0;

        tick;
        tick;
        chk("rst_busy", b1.busy, 0);
        chk("rst_wr_rd", {b1.fx_wr, b1.fx_rd, b3.fx_wr, b3.fx_rd}, 0);
        chk("rst_addr", {b1.fx_waddr, b1.fx_raddr}, 0);
        chk("rst_data", {b1.fx_data, b1.rdata0, b1.rdata1}, 0);
        chk("rst_done", {b1.done0, b1.done1}, 0);
        rst_n = 1'b1;

        // req0 write, 2-cycle latency
        b1.req0 = 1'b1; b1.we0 = 1'b1; b1.addr0 = 16'h0340; b1.wdata0 = 8'h5A;
        tick;
        chk("wr_fx_wr", b1.fx_wr, 1);
        chk("wr_fx_rd", b1.fx_rd, 0);
        chk("wr_waddr", b1.fx_waddr, 16'h0340);
        chk("wr_data", b1.fx_data, 8'h5A);
        chk("wr_busy", b1.busy, 1);
        chk("wr_early_done", b1.done0, 0);
        b1.req0 = 1'b0;
        tick;
        chk("wr_fx_wr_off", b1.fx_wr, 0);
        chk("wr_done0", b1.done0, 1);
        chk("wr_done1", b1.done1, 0);
        tick;
        chk("wr_done0_pulse", b1.done0, 0);
        chk("wr_idle", b1.busy, 0);
        chk("wr_waddr_hold", b1.fx_waddr, 16'h0340);

        // req1 read, 3-cycle latency, slave answers one cycle after fx_rd
        b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = 16'h0380;
        tick;
        chk("rd_fx_rd", b1.fx_rd, 1);
        chk("rd_fx_wr", b1.fx_wr, 0);
        chk("rd_raddr", b1.fx_raddr, 16'h0380);
        b1.req1 = 1'b0;
        tick;
        b1.fx_q = 8'h80;
        chk("rd_fx_rd_off", b1.fx_rd, 0);
        chk("rd_wait_done", b1.done1, 0);
        chk("rd_wait_busy", b1.busy, 1);
        tick;
        b1.fx_q = 8'h00;
        chk("rd_done1", b1.done1, 1);
        chk("rd_done0", b1.done0, 0);
        chk("rd_rdata1", b1.rdata1, 8'h80);
        chk("rd_rdata0", b1.rdata0, 8'h00);
        tick;
        chk("rd_done1_pulse", b1.done1, 0);
        chk("rd_rdata1_hold", b1.rdata1, 8'h80);

        // both requesters held from reset: 0,1,0,1,... with an IDLE cycle between
        rst_n = 1'b0;
        b1.req0 = 1'b1; b1.we0 = 1'b1; b1.addr0 = 16'h0100; b1.wdata0 = 8'h11;
        b1.req1 = 1'b1; b1.we1 = 1'b1; b1.addr1 = 16'h0200; b1.wdata1 = 8'h22;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("rr%0d_wr", i), b1.fx_wr, 1);
            chk($sformatf("rr%0d_waddr", i), b1.fx_waddr, (i % 2 == 0) ? 16'h0100 : 16'h0200);
            tick;
            chk($sformatf("rr%0d_done", i), {b1.done1, b1.done0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick;
            chk($sformatf("rr%0d_idle", i), {b1.busy, b1.fx_wr}, 2'b00);
        end
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
        tick;
        chk("rr_stop", b1.busy, 0);

        // RD_LAT=3: fx_q only valid in cycle t+3, done in t+4
        b3.req0 = 1'b1; b3.we0 = 1'b0; b3.addr0 = 16'h0500;
        tick;
        chk("l3_fx_rd", b3.fx_rd, 1);
        chk("l3_raddr", b3.fx_raddr, 16'h0500);
        b3.req0 = 1'b0;
        tick;
        chk("l3_t1_done", b3.done0, 0);
        tick;
        chk("l3_t2_done", b3.done0, 0);
        chk("l3_t2_busy", b3.busy, 1);
        tick;
        b3.fx_q = 8'hC3;
        chk("l3_t3_done", b3.done0, 0);
        tick;
        b3.fx_q = 8'h00;
        chk("l3_done", b3.done0, 1);
        chk("l3_rdata", b3.rdata0, 8'hC3);
        tick;
        chk("l3_done_pulse", b3.done0, 0);
        chk("l3_rdata_hold", b3.rdata0, 8'hC3);

        // unmapped module id reads back zero after a nonzero read
        rd1(1'b0, 16'h0377, 8'h77, "map");
        rd1(1'b0, 16'h3F00, 8'h00, "unmap");

        // reset in WAIT drops the read; requester 0 wins first contention afterwards
        b1.req0 = 1'b1; b1.we0 = 1'b0; b1.addr0 = 16'h0380;
        tick;
        chk("ar_fx_rd", b1.fx_rd, 1);
        b1.req0 = 1'b0;
        tick;
        chk("ar_in_wait", b1.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_fx_rd_off", b1.fx_rd, 0);
        chk("ar_busy", b1.busy, 0);
        b1.req0 = 1'b1; b1.we0 = 1'b1; b1.addr0 = 16'h0111; b1.wdata0 = 8'h01;
        b1.req1 = 1'b1; b1.we1 = 1'b1; b1.addr1 = 16'h0222; b1.wdata1 = 8'h02;
        tick;
        chk("ar_no_done", {b1.done0, b1.done1}, 0);
        rst_n = 1'b1;
        tick;
        chk("ar_first_wr", b1.fx_wr, 1);
        chk("ar_first_gnt", b1.fx_waddr, 16'h0111);
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
        tick;
        chk("ar_first_done", {b1.done1, b1.done0}, 2'b01);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
